// File: rtl/present80_decrypt_if.sv
// Handshake bundle for the PRESENT-80 decryption core: request side (start/ct/key/in_ready)
// and result side (pt/pt_valid/pt_ready), plus the busy status flag.
interface present80_decrypt_if;
  logic        start;
  logic        in_ready;
  logic [63:0] ct;
  logic [79:0] key;
  logic [63:0] pt;
  logic        pt_valid;
  logic        pt_ready;
  logic        busy;

  modport master (output start, ct, key, pt_ready, input in_ready, pt, pt_valid, busy);
  modport slave  (input start, ct, key, pt_ready, output in_ready, pt, pt_valid, busy);
endinterface

// File: rtl/present80_decrypt.sv
// Iterative PRESENT-80 decryptor: forward key expansion to K32, then 31 inverse rounds.
// Optional key cache skipping the expansion is enabled with `define PRESENT_DEC_KEYCACHE_EN.
module present80_decrypt (
  input logic                clk,
  input logic                rst,
  present80_decrypt_if.slave bus
);
  localparam logic [63:0] Sbox    = 64'h21748FE3DA09B65C;
  localparam logic [63:0] SboxInv = 64'hA970364BD21C8FE5;

  typedef enum logic [2:0] {StIdle, StKeyExp, StAddK, StRound, StDone} state_e;

  state_e      state_q;
  logic [63:0] st_q, pt_q, st_next;
  logic [79:0] kr_q, kr_fwd, kr_inv, cache_k32;
  logic [4:0]  rnd_q;
  logic        in_ready_q, busy_q, pt_valid_q, cache_hit;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return Sbox[4*x +: 4];
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    return SboxInv[4*x +: 4];
  endfunction

  function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] r);
    logic [79:0] t;
    t = {k[18:0], k[79:19]};
    t[79:76] = sbox(t[79:76]);
    t[19:15] = t[19:15] ^ r;
    return t;
  endfunction

  function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] r);
    logic [79:0] t;
    t = k;
    t[19:15] = t[19:15] ^ r;
    t[79:76] = sbox_inv(t[79:76]);
    return {t[60:0], t[79:61]};
  endfunction

  // out[i] = in[16*i mod 63] undoes the bit permutation, then S^-1 on every nibble.
  function automatic logic [63:0] inv_layer(input logic [63:0] s);
    logic [63:0] p, o;
    for (int i = 0; i < 63; i++) p[i] = s[(16 * i) % 63];
    p[63] = s[63];
    for (int n = 0; n < 16; n++) o[4*n +: 4] = sbox_inv(p[4*n +: 4]);
    return o;
  endfunction

  assign kr_fwd  = key_fwd(kr_q, rnd_q);
  assign kr_inv  = key_inv(kr_q, rnd_q);
  assign st_next = inv_layer(st_q) ^ kr_inv[79:16];

`ifdef PRESENT_DEC_KEYCACHE_EN
  // The full 80-bit K32 is kept since the inverse schedule needs every bit.
  logic        cache_vld_q;
  logic [79:0] cache_key_q, cache_k32_q, user_key_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld_q <= 1'b0;
      cache_key_q <= '0;
      cache_k32_q <= '0;
      user_key_q  <= '0;
    end else begin
      if (state_q == StIdle && bus.start) user_key_q <= bus.key;
      if (state_q == StKeyExp && rnd_q == 5'd31) begin
        cache_vld_q <= 1'b1;
        cache_key_q <= user_key_q;
        cache_k32_q <= kr_fwd;
      end
    end
  end

  assign cache_hit = cache_vld_q && (bus.key == cache_key_q);
  assign cache_k32 = cache_k32_q;
`else
  assign cache_hit = 1'b0;
  assign cache_k32 = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      st_q       <= '0;
      kr_q       <= '0;
      rnd_q      <= '0;
      pt_q       <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      pt_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            st_q       <= bus.ct;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (cache_hit) begin
              kr_q    <= cache_k32;
              rnd_q   <= 5'd31;
              state_q <= StAddK;
            end else begin
              kr_q    <= bus.key;
              rnd_q   <= 5'd1;
              state_q <= StKeyExp;
            end
          end
        end
        StKeyExp: begin
          kr_q <= kr_fwd;
          if (rnd_q == 5'd31) state_q <= StAddK;
          else rnd_q <= rnd_q + 5'd1;
        end
        StAddK: begin
          st_q    <= st_q ^ kr_q[79:16];
          state_q <= StRound;
        end
        StRound: begin
          st_q  <= st_next;
          kr_q  <= kr_inv;
          rnd_q <= rnd_q - 5'd1;
          if (rnd_q == 5'd1) begin
            pt_q       <= st_next;
            pt_valid_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= StDone;
          end
        end
        StDone: begin
          if (bus.pt_ready) begin
            pt_valid_q <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.pt_valid = pt_valid_q;
  assign bus.pt       = pt_q;
endmodule
